serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: out_diff = (in_a - in_b) mod 2^WIDTH, one bit per clock,
// with a start/busy/done handshake and results held until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             a0, b0, d_bit, br_next;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_shift;

    // One full-subtractor cell; the result register shifts the new bit in from the top.
    assign a0        = sa_q[0];
    assign b0        = sb_q[0];
    assign d_bit     = a0 ^ b0 ^ br_q;
    assign br_next   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    assign res_ext   = {d_bit, res_q};
    assign res_shift = res_ext[WIDTH:1];

    always_comb begin
        // NOTE: every variable gets a hold default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    sa_d    = in_a;
                    sb_d    = in_b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = res_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d  = S_DONE;
                    diff_d   = res_shift;
                    borrow_d = br_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign out_diff   = diff_q;
    assign out_borrow = borrow_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for handshake/timing cases and
// a 4-bit instance checked exhaustively against (a-b) mod 16 and a<b.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] in_a8, in_b8, diff8;
    logic       borrow8, busy8, done8;

    logic       start4;
    logic [3:0] in_a4, in_b4, diff4;
    logic       borrow4, busy4, done4;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .in_a       (in_a8),
        .in_b       (in_b8),
        .out_diff   (diff8),
        .out_borrow (borrow8),
        .busy       (busy8),
        .done       (done8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .in_a       (in_a4),
        .in_b       (in_b4),
        .out_diff   (diff4),
        .out_borrow (borrow4),
        .busy       (busy4),
        .done       (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge with the 8-bit DUT in IDLE or DONE; returns at the falling edge after done drops.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_diff, input logic exp_borrow);
        in_a8  = a;
        in_b8  = b;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        in_a8  = ~a;
        in_b8  = ~b;
        for (int i = 0; i < 8; i++) begin
            check({tag, "_busy"}, 32'(busy8), 32'd1);
            check({tag, "_nodone"}, 32'(done8), 32'd0);
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done8), 32'd1);
        check({tag, "_busy_low"}, 32'(busy8), 32'd0);
        check({tag, "_diff"}, 32'(diff8), 32'(exp_diff));
        check({tag, "_borrow"}, 32'(borrow8), 32'(exp_borrow));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int done_count;

        rst_n  = 1'b0;
        start8 = 1'b0;
        in_a8  = '0;
        in_b8  = '0;
        start4 = 1'b0;
        in_a4  = '0;
        in_b4  = '0;

        // Reset state
        #12;
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_borrow", 32'(borrow8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic operation and operand sweep
        op8("op_5m3", 8'd5, 8'd3, 8'h02, 1'b0);
        op8("op_3m5", 8'd3, 8'd5, 8'hFE, 1'b1);
        op8("op_0m0", 8'h00, 8'h00, 8'h00, 1'b0);
        op8("op_ffm01", 8'hFF, 8'h01, 8'hFE, 1'b0);
        op8("op_00mff", 8'h00, 8'hFF, 8'h01, 1'b1);
        op8("op_80m80", 8'h80, 8'h80, 8'h00, 1'b0);

        // start re-pulsed mid-RUN with new operands must be ignored
        in_a8  = 8'd5;
        in_b8  = 8'd3;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                start8 = 1'b1;
                in_a8  = 8'd9;
                in_b8  = 8'd9;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                done_count++;
                check("midstart_diff", 32'(diff8), 32'h02);
                check("midstart_borrow", 32'(borrow8), 32'd0);
            end
            @(negedge clk);
        end
        check("midstart_done_count", 32'(done_count), 32'd1);
        check("midstart_idle", 32'(busy8), 32'd0);

        // Back-to-back: start held in DONE restarts RUN immediately
        in_a8  = 8'd5;
        in_b8  = 8'd3;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_first_done", 32'(done8), 32'd1);
        check("b2b_first_diff", 32'(diff8), 32'h02);
        in_a8  = 8'h10;
        in_b8  = 8'h20;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_restart_busy", 32'(busy8), 32'd1);
        check("b2b_restart_nodone", 32'(done8), 32'd0);
        repeat (3) @(negedge clk);
        check("b2b_hold_diff", 32'(diff8), 32'h02);
        check("b2b_hold_borrow", 32'(borrow8), 32'd0);
        repeat (4) @(negedge clk);
        check("b2b_second_early", 32'(done8), 32'd0);
        @(negedge clk);
        check("b2b_second_done", 32'(done8), 32'd1);
        check("b2b_second_diff", 32'(diff8), 32'hF0);
        check("b2b_second_borrow", 32'(borrow8), 32'd1);
        @(negedge clk);

        // Asynchronous reset in the 4th RUN cycle aborts the operation
        in_a8  = 8'hFF;
        in_b8  = 8'h01;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_borrow", 32'(borrow8), 32'd0);
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_count = 0;
        for (int i = 0; i < 10; i++) begin
            if (done8) done_count++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_count), 32'd0);
        op8("after_abort_7m2", 8'd7, 8'd2, 8'h05, 1'b0);

        // Exhaustive WIDTH=4
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] exp_d;
                logic       exp_b;
                exp_d  = 4'((a - b) & 15);
                exp_b  = (a < b);
                in_a4  = 4'(a);
                in_b4  = 4'(b);
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                in_a4  = 4'(~a);
                repeat (4) @(negedge clk);
                if (!done4) begin
                    check("w4_done", 32'(done4), 32'd1);
                end
                check($sformatf("w4_diff_%0d_%0d", a, b), 32'(diff4), 32'(exp_d));
                check($sformatf("w4_borrow_%0d_%0d", a, b), 32'(borrow4), 32'(exp_b));
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
